// File: rtl/ad77684_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ad77684_pkg
//  Purpose : Shared definitions for the AD7768-4 frame packer: header field
//            positions, packer state type, default sizes and the lane
//            formatting helper.
//  Rev     : 1.0  initial release
// ============================================================================
package ad77684_pkg;

    // Header field positions inside the 32-bit ADC word
    localparam int HDR_ERR_BIT = 31;
    localparam int CH_ID_MSB   = 26;
    localparam int CH_ID_LSB   = 24;
    localparam int SAMPLE_W    = 24;
    localparam int CH_ID_W     = CH_ID_MSB - CH_ID_LSB + 1;

    // Default sizes
    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } ad77684_pack_state_t;

    // Output lane: sign-extended sample, or the raw 32-bit word
    function automatic logic [31:0] fmt_lane(input logic [31:0] word,
                                             input logic        sext);
        logic [31:0] lane;
        if (sext)
            lane = {{(32-SAMPLE_W){word[SAMPLE_W-1]}}, word[SAMPLE_W-1:0]};
        else
            lane = word;
        return lane;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad77684_frame_pack_if.sv
`default_nettype none
// ============================================================================
//  Module  : ad77684_frame_pack_if
//  Purpose : Valid/ready frame stream from the packer toward the DMA/packer.
//  Signals : m_valid   - frame available (driven by master)
//            m_ready   - downstream accepts the frame (driven by slave)
//            m_data    - NUM_CH lanes of 32 bits, lane k at [32k+31:32k]
//            m_hdr_err - per-lane copy of header error bit
//  Rev     : 1.0  initial release
// ============================================================================
interface ad77684_frame_pack_if #(
    parameter int NUM_CH = 4
);
    logic                   m_valid;
    logic                   m_ready;
    logic [NUM_CH*32-1:0]   m_data;
    logic [NUM_CH-1:0]      m_hdr_err;

    modport master (output m_valid, output m_data, output m_hdr_err, input  m_ready);
    modport slave  (input  m_valid, input  m_data, input  m_hdr_err, output m_ready);
endinterface
`default_nettype wire

// File: rtl/ad77684_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module  : ad77684_sat_cnt
//  Purpose : Saturating up-counter with synchronous clear; clear has priority
//            over increment.
//  Ports   : clk, rst_n (async active-low), inc, clr, cnt[CNT_W-1:0]
//  Rev     : 1.0  initial release
// ============================================================================
module ad77684_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              inc,
    input  wire              clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ad77684_frame_pack.sv
`default_nettype none
// ============================================================================
//  Module  : ad77684_frame_pack
//  Purpose : Collects the per-channel 32-bit ADC word stream, checks the
//            channel-ID sequence and emits one parallel frame of NUM_CH lanes
//            on a valid/ready stream, with sequence-error / overflow counters.
//  Ports   : adc_clk, adc_resetn (async active-low)
//            adc_valid, adc_data[31:0], fmt_sext      - word stream input
//            m_if (master)                            - frame stream output
//            locked                                   - sequencing aligned
//            status_clr, seq_err_cnt, ovf_cnt         - status bank
//  Rev     : 1.0  initial release
// ============================================================================
module ad77684_frame_pack
    import ad77684_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  wire                         adc_clk,
    input  wire                         adc_resetn,
    input  wire                         adc_valid,
    input  wire  [31:0]                 adc_data,
    input  wire                         fmt_sext,
    ad77684_frame_pack_if.master        m_if,
    output logic                        locked,
    input  wire                         status_clr,
    output logic [CNT_W-1:0]            seq_err_cnt,
    output logic [CNT_W-1:0]            ovf_cnt
);

    localparam int                 c_IDX_W    = CH_ID_W;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_CH - 1);

    ad77684_pack_state_t    r_state;
    logic [c_IDX_W-1:0]     r_idx;
    logic [NUM_CH*32-1:0]   r_stage_data;
    logic [NUM_CH-1:0]      r_stage_err;
    logic                   r_frame_rdy;   // staging holds a complete frame
    logic                   r_m_valid;
    logic [NUM_CH*32-1:0]   r_m_data;
    logic [NUM_CH-1:0]      r_m_hdr_err;
    logic                   r_locked;

    logic [c_IDX_W-1:0]     w_id;
    logic [31:0]            w_lane;
    logic                   w_hdr_err;
    logic                   w_id_match;
    logic                   w_last;
    logic                   w_hs;
    logic                   w_load;
    logic                   w_ovf;
    logic                   w_seq_err;

    assign w_id       = adc_data[CH_ID_MSB:CH_ID_LSB];
    assign w_lane     = fmt_lane(adc_data, fmt_sext);
    assign w_hdr_err  = adc_data[HDR_ERR_BIT];
    // IDs >= NUM_CH can never equal r_idx, so they fall out as sequence errors
    assign w_id_match = (w_id == r_idx);
    assign w_last     = (r_idx == c_LAST_IDX);

    assign w_hs       = r_m_valid && m_if.m_ready;
    // A completed staging frame moves out only when the output slot frees up
    // in the same edge; otherwise it is dropped and counted.
    assign w_load     = r_frame_rdy && (!r_m_valid || w_hs);
    assign w_ovf      = r_frame_rdy && !w_load;
    assign w_seq_err  = adc_valid && (r_state == COLLECT) && !w_id_match;

    always_ff @(posedge adc_clk or negedge adc_resetn) begin
        if (!adc_resetn) begin
            r_state      <= HUNT;
            r_idx        <= '0;
            r_stage_data <= '0;
            r_stage_err  <= '0;
            r_frame_rdy  <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_hdr_err  <= '0;
            r_locked     <= 1'b0;
        end else begin
            // Output register: load from staging, or retire on handshake
            if (w_load) begin
                r_m_valid   <= 1'b1;
                r_m_data    <= r_stage_data;
                r_m_hdr_err <= r_stage_err;
                r_locked    <= 1'b1;
            end else if (w_hs) begin
                r_m_valid   <= 1'b0;
            end

            r_frame_rdy <= 1'b0;

            // Word sequencing; a sequence error here overrides a same-edge
            // lock from the load above because it is the newer event.
            if (adc_valid) begin
                case (r_state)
                    HUNT: begin
                        if (w_id == '0) begin
                            r_stage_data[31:0] <= w_lane;
                            r_stage_err[0]     <= w_hdr_err;
                            r_idx              <= c_IDX_W'(1);
                            r_state            <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (w_id_match) begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                if (r_idx == c_IDX_W'(k)) begin
                                    r_stage_data[k*32 +: 32] <= w_lane;
                                    r_stage_err[k]           <= w_hdr_err;
                                end
                            end
                            if (w_last) begin
                                r_idx       <= '0;
                                r_frame_rdy <= 1'b1;
                            end else begin
                                r_idx       <= r_idx + c_IDX_W'(1);
                            end
                        end else begin
                            r_locked <= 1'b0;
                            if (w_id == '0) begin
                                // Mismatched ID 0 starts a fresh frame at once
                                r_stage_data[31:0] <= w_lane;
                                r_stage_err[0]     <= w_hdr_err;
                                r_idx              <= c_IDX_W'(1);
                            end else begin
                                r_state <= HUNT;
                                r_idx   <= '0;
                            end
                        end
                    end
                    default: begin
                        r_state <= HUNT;
                        r_idx   <= '0;
                    end
                endcase
            end
        end
    end

    assign m_if.m_valid   = r_m_valid;
    assign m_if.m_data    = r_m_data;
    assign m_if.m_hdr_err = r_m_hdr_err;
    assign locked         = r_locked;

    ad77684_sat_cnt #(.CNT_W(CNT_W)) u_seq_err_cnt (
        .clk   (adc_clk),
        .rst_n (adc_resetn),
        .inc   (w_seq_err),
        .clr   (status_clr),
        .cnt   (seq_err_cnt)
    );

    ad77684_sat_cnt #(.CNT_W(CNT_W)) u_ovf_cnt (
        .clk   (adc_clk),
        .rst_n (adc_resetn),
        .inc   (w_ovf),
        .clr   (status_clr),
        .cnt   (ovf_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_ad77684_frame_pack.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ad77684_frame_pack
//  Purpose : Self-checking bench for ad77684_frame_pack: directed scenarios
//            followed by randomized word streams compared every cycle against
//            a queue-based frame model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_ad77684_frame_pack;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        adc_resetn;
    logic        adc_valid;
    logic [31:0] adc_data;
    logic        fmt_sext;
    logic        status_clr;
    logic        locked;
    logic [15:0] seq_err_cnt;
    logic [15:0] ovf_cnt;

    always #5 clk = ~clk;

    ad77684_frame_pack_if #(.NUM_CH(NCH)) m_if ();

    ad77684_frame_pack #(.NUM_CH(NCH), .CNT_W(16)) dut (
        .adc_clk     (clk),
        .adc_resetn  (adc_resetn),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .fmt_sext    (fmt_sext),
        .m_if        (m_if),
        .locked      (locked),
        .status_clr  (status_clr),
        .seq_err_cnt (seq_err_cnt),
        .ovf_cnt     (ovf_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int nv       = 0;   // cycles observed with m_valid high

    // ---------------- reference model ----------------
    bit           m_hunt;
    logic [32:0]  m_q[$];        // {hdr_err, formatted lane} of partial frame
    bit           m_pend;
    logic [127:0] m_pend_data;
    logic [3:0]   m_pend_err;
    logic         e_mv;
    logic         e_locked;
    logic [127:0] e_data;
    logic [3:0]   e_err;
    int           e_seq;
    int           e_ovf;

    function automatic logic [31:0] mk(input bit e, input logic [2:0] id, input logic [23:0] s);
        return {e, 4'b0000, id, s};
    endfunction

    function automatic logic [31:0] lane_of(input logic [31:0] w, input bit sx);
        return sx ? {{8{w[23]}}, w[23:0]} : w;
    endfunction

    task automatic model_reset();
        m_hunt = 1; m_q.delete(); m_pend = 0; m_pend_data = '0; m_pend_err = '0;
        e_mv = 0; e_locked = 0; e_data = '0; e_err = '0; e_seq = 0; e_ovf = 0;
    endtask

    task automatic model_edge();
        bit hs, seqinc, ovfinc;
        int id;
        if (!adc_resetn) begin
            model_reset();
            return;
        end
        hs = e_mv && m_if.m_ready;
        seqinc = 0; ovfinc = 0;
        // frame completed on the previous edge reaches the output now
        if (m_pend) begin
            if (!e_mv || hs) begin
                e_data = m_pend_data; e_err = m_pend_err; e_mv = 1; e_locked = 1;
            end else begin
                ovfinc = 1;
            end
        end else if (hs) begin
            e_mv = 0;
        end
        m_pend = 0;
        if (adc_valid) begin
            id = int'(adc_data[26:24]);
            if (m_hunt) begin
                if (id == 0) begin
                    m_q.push_back({adc_data[31], lane_of(adc_data, fmt_sext)});
                    m_hunt = 0;
                end
            end else if (id == m_q.size()) begin
                m_q.push_back({adc_data[31], lane_of(adc_data, fmt_sext)});
                if (m_q.size() == NCH) begin
                    for (int k = 0; k < NCH; k++) begin
                        m_pend_data[k*32 +: 32] = m_q[k][31:0];
                        m_pend_err[k]           = m_q[k][32];
                    end
                    m_pend = 1;
                    m_q.delete();
                end
            end else begin
                seqinc = 1; e_locked = 0;
                m_q.delete();
                if (id == 0) m_q.push_back({adc_data[31], lane_of(adc_data, fmt_sext)});
                else         m_hunt = 1;
            end
        end
        if (status_clr) e_seq = 0; else if (seqinc && e_seq < 65535) e_seq++;
        if (status_clr) e_ovf = 0; else if (ovfinc && e_ovf < 65535) e_ovf++;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("m_valid",     128'(m_if.m_valid),   128'(e_mv));
        chk("m_data",      m_if.m_data,          e_data);
        chk("m_hdr_err",   128'(m_if.m_hdr_err), 128'(e_err));
        chk("locked",      128'(locked),         128'(e_locked));
        chk("seq_err_cnt", 128'(seq_err_cnt),    128'(e_seq));
        chk("ovf_cnt",     128'(ovf_cnt),        128'(e_ovf));
    endtask

    task automatic cyc(input bit v, input logic [31:0] d, input bit f, input bit r, input bit c);
        adc_valid = v; adc_data = d; fmt_sext = f; m_if.m_ready = r; status_clr = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (m_if.m_valid) nv++;
    endtask

    task automatic idle(input bit r);
        cyc(0, 32'h0, 0, r, 0);
    endtask

    logic [31:0]  fw[4][4];
    logic [127:0] exp_frame;
    int           nv0;
    int           gid;

    initial begin
        adc_resetn = 0; adc_valid = 0; adc_data = '0; fmt_sext = 0;
        status_clr = 0; m_if.m_ready = 0;
        model_reset();
        idle(0); idle(0);
        chk("rst_m_valid", 128'(m_if.m_valid), 128'd0);
        chk("rst_m_data",  m_if.m_data,        128'd0);
        chk("rst_seq",     128'(seq_err_cnt),  128'd0);
        adc_resetn = 1;
        idle(1);

        // Sign-extended frame, single-cycle valid pulse after the last word
        cyc(1, mk(0, 0, 24'h800001), 1, 1, 0);
        cyc(1, mk(0, 1, 24'h7FFFFF), 1, 1, 0);
        cyc(1, mk(0, 2, 24'h000000), 1, 1, 0);
        cyc(1, mk(0, 3, 24'hFFFFFF), 1, 1, 0);
        chk("t1_latency", 128'(m_if.m_valid), 128'd0);
        idle(1);
        chk("t1_valid",  128'(m_if.m_valid), 128'd1);
        chk("t1_data",   m_if.m_data, 128'hFFFFFFFF_00000000_007FFFFF_FF800001);
        chk("t1_locked", 128'(locked), 128'd1);
        idle(1);
        chk("t1_pulse", 128'(m_if.m_valid), 128'd0);

        // Raw frame with header error on channel 2
        cyc(1, mk(0, 0, 24'h800001), 0, 1, 0);
        cyc(1, mk(0, 1, 24'h7FFFFF), 0, 1, 0);
        cyc(1, mk(1, 2, 24'h000000), 0, 1, 0);
        cyc(1, mk(0, 3, 24'hFFFFFF), 0, 1, 0);
        idle(1);
        chk("t2_data", m_if.m_data, {mk(0,3,24'hFFFFFF), mk(1,2,24'h0), mk(0,1,24'h7FFFFF), mk(0,0,24'h800001)});
        chk("t2_hdr",  128'(m_if.m_hdr_err), 128'(4'b0100));
        idle(1);

        // Sequence error 0,1,3 then a clean 0..3
        nv0 = nv;
        cyc(1, mk(0, 0, 24'h111111), 0, 1, 0);
        cyc(1, mk(0, 1, 24'h222222), 0, 1, 0);
        chk("t3_locked_before", 128'(locked), 128'd1);
        cyc(1, mk(0, 3, 24'h333333), 0, 1, 0);
        chk("t3_locked_drop", 128'(locked), 128'd0);
        chk("t3_seq", 128'(seq_err_cnt), 128'd1);
        for (int k = 0; k < 4; k++) cyc(1, mk(0, 3'(k), 24'hA00000 + 24'(k)), 0, 1, 0);
        idle(1);
        chk("t3_data", m_if.m_data, {mk(0,3,24'hA00003), mk(0,2,24'hA00002), mk(0,1,24'hA00001), mk(0,0,24'hA00000)});
        idle(1);
        chk("t3_frames", 128'(nv - nv0), 128'd1);

        // Reset mid-frame, then stream starting at ID 2 (discarded in HUNT)
        cyc(1, mk(0, 0, 24'h000123), 0, 1, 0);
        cyc(1, mk(0, 1, 24'h000456), 0, 1, 0);
        adc_resetn = 0;
        idle(1);
        chk("t4_rst_data",   m_if.m_data,          128'd0);
        chk("t4_rst_seq",    128'(seq_err_cnt),    128'd0);
        chk("t4_rst_locked", 128'(locked),         128'd0);
        adc_resetn = 1;
        nv0 = nv;
        cyc(1, mk(0, 2, 24'h0), 0, 1, 0);
        cyc(1, mk(0, 3, 24'h0), 0, 1, 0);
        for (int k = 0; k < 4; k++) cyc(1, mk(0, 3'(k), 24'hB0000 + 24'(k)), 0, 1, 0);
        idle(1); idle(1);
        chk("t4_seq",    128'(seq_err_cnt), 128'd0);
        chk("t4_frames", 128'(nv - nv0),    128'd1);

        // Back-pressure: three frames while stalled, fourth loads on handshake
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 4; k++) fw[f][k] = mk(0, 3'(k), 24'($urandom));
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 4; k++) cyc(1, fw[f][k], 0, 0, 0);
        idle(0);
        exp_frame = {fw[0][3], fw[0][2], fw[0][1], fw[0][0]};
        chk("t5_held", m_if.m_data, exp_frame);
        chk("t5_ovf",  128'(ovf_cnt), 128'd2);
        for (int k = 0; k < 4; k++) cyc(1, fw[3][k], 0, 0, 0);
        idle(1);
        exp_frame = {fw[3][3], fw[3][2], fw[3][1], fw[3][0]};
        chk("t5_f4_data",  m_if.m_data, exp_frame);
        chk("t5_f4_valid", 128'(m_if.m_valid), 128'd1);
        chk("t5_f4_ovf",   128'(ovf_cnt), 128'd2);
        idle(1);

        // Counter saturation and clear priority
        cyc(0, 32'h0, 0, 1, 1);
        for (int i = 0; i < 65538; i++) cyc(1, mk(0, 0, 24'(i)), 0, 1, 0);
        chk("t6_sat", 128'(seq_err_cnt), 128'h0000FFFF);
        cyc(1, mk(0, 0, 24'h0), 0, 1, 1);
        chk("t6_clr_wins", 128'(seq_err_cnt), 128'd0);

        // Randomized streams
        gid = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] id;
            bit         v;
            v  = ($urandom_range(0, 3) != 0);
            id = 3'(gid);
            if ($urandom_range(0, 11) == 0) id = 3'($urandom_range(0, 7));
            if (v) gid = (gid + 1) % NCH;
            if ($urandom_range(0, 499) == 0) adc_resetn = 0;
            cyc(v, mk(1'($urandom_range(0, 1)), id, 24'($urandom)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 199) == 0));
            adc_resetn = 1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ad77684_frame_pack.md
# ad77684_frame_pack

Downstream stage of the AD7768-4 serial interface. Consumes its per-channel 32-bit word stream (`adc_valid`/`adc_data`: 8-bit header + 24-bit sample), checks channel-ID sequencing, and assembles one parallel frame of all channels. The frame is presented on a valid/ready output toward the DMA/packer, with sequence-error and overflow status for the up-register bank.

## Interface
- `NUM_CH`, 4: channels per frame; channel IDs 0..NUM_CH-1.
- `CNT_W`, 16: width of the status counters.
- `adc_clk` in 1: the single clock. Same domain as the interface's `adc_clk`.
- `adc_resetn` in 1: reset, asynchronous, active-low.
- `adc_valid` in 1: one-cycle strobe; `adc_data` is valid when high.
- `adc_data` in 32: `[31]` error flag, `[30:27]` status flags (ignored), `[26:24]` channel ID, `[23:0]` two's-complement sample.
- `fmt_sext` in 1: 1 = output lane is `{8{data[23]}, data[23:0]}`; 0 = raw 32-bit word. Sampled per word.
- `m_valid` out 1: frame available.
- `m_ready` in 1: downstream accepts the frame.
- `m_data` out NUM_CH*32: lane k holds channel k (bits `[32k+31:32k]`).
- `m_hdr_err` out NUM_CH: bit k is header `[31]` of channel k's word.
- `locked` out 1: sequencing is aligned.
- `status_clr` in 1: synchronous clear of both counters.
- `seq_err_cnt` out CNT_W: saturating count of sequence errors.
- `ovf_cnt` out CNT_W: saturating count of dropped frames.

## Operation
- FSM states:
  - `HUNT`: discard words until ID==0, then store lane 0 and go to `COLLECT` with `idx`=1.
  - `COLLECT`: an accepted word must carry ID==`idx`. Store it and increment `idx`.
  - When `idx` was NUM_CH-1, the frame is complete. Go to `COLLECT` with `idx`=0.
- Sequence error (in `COLLECT`, ID≠`idx`):
  - Increment `seq_err_cnt` and clear `locked`.
  - Discard the partial frame.
  - If the ID is 0, restart the frame at `idx`=1. Otherwise go to `HUNT`.
- IDs ≥ NUM_CH always count as sequence errors in `COLLECT`.
- Assembly goes into a staging register. On completion the staging register moves to the output register.
- Frame completion, output handling:
  - Output register empty, or `m_valid&&m_ready` in the same cycle: load the output register, set `m_valid`, set `locked`.
  - Otherwise: drop the new frame, increment `ovf_cnt`. The held frame is unchanged and `locked` is unaffected.
- Counters saturate at all-ones.
- If `status_clr` and an increment occur in the same cycle, clear wins (result 0).
- Reset values: state `HUNT`, `idx` 0, `m_valid` 0, `m_data` 0, `m_hdr_err` 0, `locked` 0, both counters 0.
- Reset may assert mid-frame or while `m_valid` is held. The frame is lost and no counter increments.

## Timing
- Completing word accepted at edge t: `m_valid`=1 and the new `m_data` are visible after edge t+1 (one-cycle latency).
- `m_data`/`m_hdr_err` are stable while `m_valid && !m_ready`.
- `m_valid` drops the cycle after a handshake unless a new frame completes in that same cycle.
- Back-to-back `adc_valid` every cycle is supported. Full throughput is one frame per NUM_CH cycles when `m_ready`=1.
- `m_ready` is ignored while `m_valid`=0. No combinational path from `m_ready` to `m_valid`.

## Structure
- Package `ad77684_pkg`:
  - header field positions (`HDR_ERR_BIT`=31, `CH_ID_MSB`=26, `CH_ID_LSB`=24, `SAMPLE_W`=24);
  - `ad77684_pack_state_t` enum {`HUNT`, `COLLECT`};
  - default `NUM_CH`.
- Sub-module `ad77684_sat_cnt` (CNT_W saturating counter with `inc` and synchronous `clr`, clear priority), instantiated twice.

## Test plan
- Words with IDs 0,1,2,3, samples `24'h800001`, `24'h7FFFFF`, `24'h000000`, `24'hFFFFFF`, `fmt_sext`=1, `m_ready`=1 → one `m_valid` pulse one cycle after the last word:
  - lanes `32'hFF800001`, `32'h007FFFFF`, `32'h00000000`, `32'hFFFFFFFF`;
  - `locked`=1.
- Same frame with `fmt_sext`=0 and header `[31]` set on ch2 → lanes equal the raw words, `m_hdr_err`=`4'b0100`.
- IDs 0,1,3,0,1,2,3 → `seq_err_cnt`=1, `locked` drops on the ID-3 word, and exactly one frame is output, made of the last four words.
- Start stream at ID 2, then 3,0,1,2,3 → 2 and 3 are discarded in `HUNT`, `seq_err_cnt`=0, one frame is output.
- `m_ready`=0 while three frames stream → first frame held unchanged, `ovf_cnt`=2. Then `m_ready`=1 alongside a fourth completing frame → fourth frame loads with no overflow.
- Force `seq_err_cnt` to 16'hFFFF plus another error → stays 16'hFFFF. `status_clr` coincident with an error → 0. Assert `adc_resetn` mid-frame → all outputs 0, state `HUNT`.
